serial_adder: RTL

//   Parametrised multi-cycle adder: adds two WIDTH-bit operands plus carry-in, CHUNK bits per clock, LSB chunk first.

---
 rtl/serial_adder_pkg.sv | 22 ++
 rtl/serial_adder_fa_chunk.sv | 34 +++
 rtl/serial_adder.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/serial_adder_pkg.sv
// Shared types and sizing helpers for the serial adder.
//   state_e    : control FSM state (idle / running / result held)
//   nchunk()   : number of chunk cycles per operation
//   cnt_width(): width of the chunk counter (at least 1 bit)
package serial_adder_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  function automatic int unsigned nchunk(int unsigned width, int unsigned chunk);
    return width / chunk;
  endfunction

  // A single-chunk build still needs a 1-bit counter to keep the logic well formed.
  function automatic int unsigned cnt_width(int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/serial_adder_fa_chunk.sv
// Combinational CHUNK-bit ripple of full-adder cells.
// Ports:
//   x, y     : chunk operands
//   ci       : carry into bit 0
//   s        : chunk sum
//   co       : carry out of the top bit
//   c_msb_in : carry into the top bit (used for signed overflow)
module fa_chunk #(
  parameter int unsigned CHUNK = 2
) (
  input  logic [CHUNK-1:0] x,
  input  logic [CHUNK-1:0] y,
  input  logic             ci,
  output logic [CHUNK-1:0] s,
  output logic             co,
  output logic             c_msb_in
);

  logic [CHUNK:0] c;

  always_comb begin
    c    = '0;
    s    = '0;
    c[0] = ci;
    for (int i = 0; i < int'(CHUNK); i++) begin
      s[i]   = x[i] ^ y[i] ^ c[i];
      c[i+1] = (x[i] & y[i]) | (x[i] & c[i]) | (y[i] & c[i]);
    end
  end

  assign co       = c[CHUNK];
  assign c_msb_in = c[CHUNK-1];

endmodule

// File: rtl/serial_adder.sv
// Multi-cycle adder: a + b + cin, CHUNK bits per clock, LSB chunk first.
// Valid/ready handshake on both sides; one result per NCHUNK+2 cycles.
// Ports:
//   clk, rst_n           : clock (rising edge), asynchronous active-low reset
//   in_valid / in_ready  : operand handshake (a, b, cin, sub sampled on accept)
//   a, b, cin            : operands and carry-in
//   sub                  : subtract select (only with SERIAL_ADDER_SUB_EN)
//   out_valid / out_ready: result handshake
//   sum, cout, ovf       : result, carry-out of MSB, signed overflow
// Build option: define SERIAL_ADDER_SUB_EN to add the sub port (a - b via ~b + 1).
module serial_adder #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CHUNK = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  import serial_adder_pkg::*;

  localparam int unsigned NCHUNK = nchunk(WIDTH, CHUNK);
  localparam int unsigned CNT_W  = cnt_width(NCHUNK);
  localparam logic [CNT_W-1:0] LastCnt = CNT_W'(NCHUNK - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [CHUNK-1:0] chunk_s;
  logic             chunk_co;
  logic             chunk_c_msb;
  logic [WIDTH-1:0] chunk_top;

  fa_chunk #(
    .CHUNK(CHUNK)
  ) u_fa_chunk (
    .x       (a_q[CHUNK-1:0]),
    .y       (b_q[CHUNK-1:0]),
    .ci      (carry_q),
    .s       (chunk_s),
    .co      (chunk_co),
    .c_msb_in(chunk_c_msb)
  );

  // New chunk enters at the top so the LSB chunk ends up at bit 0 after NCHUNK shifts.
  assign chunk_top = WIDTH'(chunk_s) << (WIDTH - CHUNK);

  // Gated with rst_n so no operand is offered while reset is held.
  assign in_ready  = (state_q == StIdle) && rst_n;
  assign out_valid = (state_q == StDone);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    ovf_d   = ovf_q;
    case (state_q)
      StIdle: begin
        if (in_valid && in_ready) begin
          a_d     = a;
          b_d     = b;
          carry_d = cin;
`ifdef SERIAL_ADDER_SUB_EN
          if (sub) begin
            b_d     = ~b;
            carry_d = 1'b1;
          end
`endif
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        sum_d   = (sum_q >> CHUNK) | chunk_top;
        carry_d = chunk_co;
        if (cnt_q == LastCnt) begin
          cout_d  = chunk_co;
          ovf_d   = chunk_co ^ chunk_c_msb;
          state_d = StDone;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      StDone: begin
        if (out_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      a_q     <= a_d;
      b_q     <= b_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

endmodule
